// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end; deserialises MOSI words to rx_data and serialises RAM read data onto MISO.
module spi_slave_if #(
  parameter int WORD_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int TW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
  state_t state, next;
  logic [CW-1:0] bit_cnt;
  logic [TW-1:0] tx_cnt;
  logic [WORD_W-2:0] shift;
  logic [DATA_W-1:0] tx_shift;
  logic read_addr_done, tx_busy, tx_done;
  logic rx_busy, rx_last, tx_start;
  // bit_cnt saturates at WORD_W once a word is complete, locking out further bits in this frame
  assign rx_busy  = (state inside {WRITE, READ_ADD, READ_DATA}) && bit_cnt != CW'(WORD_W);
  assign rx_last  = rx_busy && bit_cnt == CW'(WORD_W - 1);
  assign tx_start = state == READ_DATA && bit_cnt == CW'(WORD_W) && !tx_busy && !tx_done && tx_valid;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (SS_n) next = IDLE;
    else if (state == IDLE) next = CHK_CMD;
    else if (state == CHK_CMD) next = !MOSI ? WRITE : read_addr_done ? READ_DATA : READ_ADD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt        <= '0;
      tx_cnt         <= '0;
      shift          <= '0;
      tx_shift       <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      MISO           <= 1'b0;
      read_addr_done <= 1'b0;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
    end else if (SS_n) begin
      bit_cnt  <= '0;
      tx_cnt   <= '0;
      rx_valid <= 1'b0;
      MISO     <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_busy) begin
        shift   <= {shift[WORD_W-3:0], MOSI};
        bit_cnt <= bit_cnt + 1'b1;
        if (rx_last) begin
          rx_data  <= {shift, MOSI};
          rx_valid <= 1'b1;
          if (state == READ_ADD) read_addr_done <= 1'b1;
        end
      end
      if (tx_start) begin
        MISO     <= tx_data[DATA_W-1];
        tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
        tx_cnt   <= TW'(1);
        tx_busy  <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt == TW'(DATA_W)) begin
          MISO           <= 1'b0;
          read_addr_done <= 1'b0;
          tx_busy        <= 1'b0;
          tx_done        <= 1'b1;
        end else begin
          MISO     <= tx_shift[DATA_W-1];
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          tx_cnt   <= tx_cnt + 1'b1;
        end
      end
    end
  end
endmodule
